// File: rtl/hidden_arb_pkg.sv
// Shared types and default widths for the hidden-layer AER spike arbiter.
package hidden_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

  localparam int HA_ADDR_W = 4;
  localparam int HA_CNT_W  = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping mod N_NEURON.
module rr_priority_pick
  import hidden_arb_pkg::*;
#(
  parameter int N_NEURON = 16,
  parameter int ADDR_W   = HA_ADDR_W
) (
  input  logic [N_NEURON-1:0] req,
  input  logic [ADDR_W-1:0]   rr_ptr,
  output logic                found,
  output logic [ADDR_W-1:0]   winner
);

  logic [N_NEURON-1:0] req_rot;
  logic [ADDR_W-1:0]   offset;
  logic [ADDR_W:0]     sum;

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    req_rot = N_NEURON'({req, req} >> rr_ptr);
    offset  = '0;
    // Scanning from the top down leaves the lowest set bit in offset.
    for (int i = N_NEURON - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = ADDR_W'(i);
    end
    found = |req_rot;
    sum   = {1'b0, offset} + {1'b0, rr_ptr};
    if (sum >= (ADDR_W + 1)'(N_NEURON)) sum = sum - (ADDR_W + 1)'(N_NEURON);
    winner = ADDR_W'(sum);
  end

endmodule

// File: rtl/hidden_spike_arbiter.sv
// Round-robin AER arbiter for the hidden-neuron array plus the shared refractory timestep tick.
// Optional accepted-event counter enabled by defining HIDDEN_ARB_EVENT_CNT_EN.
module hidden_spike_arbiter
  import hidden_arb_pkg::*;
#(
  parameter int N_NEURON    = 16,
  parameter int ADDR_W      = HA_ADDR_W,
  parameter int STEP_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N_NEURON-1:0] spike_req,
  output logic [N_NEURON-1:0] ack_out,
  output logic                aer_valid,
  output logic [ADDR_W-1:0]   aer_addr,
  input  logic                aer_ready,
  input  logic                run_en,
  output logic                timer_en,
  output logic                busy,
  output logic [HA_CNT_W-1:0] event_count
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  arb_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic [N_NEURON-1:0] ack_q, ack_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                tick_q, tick_d;
  logic                found;
  logic [ADDR_W-1:0]   winner;
  logic                xfer;

  rr_priority_pick #(.N_NEURON(N_NEURON), .ADDR_W(ADDR_W)) u_pick (
    .req    (spike_req),
    .rr_ptr (rr_ptr_q),
    .found  (found),
    .winner (winner)
  );

  // valid_q is only ever high in GRANT, so this is the accepted-transfer strobe.
  assign xfer = (state_q == GRANT) && aer_ready;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    ack_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          addr_d  = winner;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (aer_ready) begin
          valid_d  = 1'b0;
          ack_d    = N_NEURON'(1) << addr_q;
          rr_ptr_d = (addr_q == ADDR_W'(N_NEURON - 1)) ? '0 : addr_q + 1'b1;
          state_d  = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    step_d = step_q;
    tick_d = 1'b0;
    if (run_en) begin
      if (step_q == STEP_W'(STEP_CYCLES - 1)) begin
        step_d = '0;
        tick_d = 1'b1;
      end else begin
        step_d = step_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      ack_q    <= '0;
      step_q   <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
      step_q   <= step_d;
      tick_q   <= tick_d;
    end
  end

`ifdef HIDDEN_ARB_EVENT_CNT_EN
  logic [HA_CNT_W-1:0] evt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      evt_q <= '0;
    end else if (xfer && (evt_q != '1)) begin
      evt_q <= evt_q + 1'b1;
    end
  end

  assign event_count = evt_q;
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
  assign event_count = '0;
`endif

  assign ack_out   = ack_q;
  assign aer_valid = valid_q;
  assign aer_addr  = addr_q;
  assign timer_en  = tick_q;
  assign busy      = (state_q != IDLE) || (|spike_req);

endmodule

// File: tb/tb_hidden_spike_arbiter.sv
// Directed self-checking bench for hidden_spike_arbiter (N_NEURON=16, STEP_CYCLES=4).
module tb_hidden_spike_arbiter;

  localparam int N    = 16;
  localparam int AW   = 4;
  localparam int STEP = 4;
`ifdef HIDDEN_ARB_EVENT_CNT_EN
  localparam int EXP_EVT = 5;
`else
  localparam int EXP_EVT = 0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic [N-1:0]  spike_req;
  logic [N-1:0]  ack_out;
  logic          aer_valid;
  logic [AW-1:0] aer_addr;
  logic          aer_ready;
  logic          run_en;
  logic          timer_en;
  logic          busy;
  logic [15:0]   event_count;

  logic [N-1:0]  keep_mask;
  int            n_checks = 0;
  int            n_errors = 0;

  hidden_spike_arbiter #(.N_NEURON(N), .ADDR_W(AW), .STEP_CYCLES(STEP)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .spike_req   (spike_req),
    .ack_out     (ack_out),
    .aer_valid   (aer_valid),
    .aer_addr    (aer_addr),
    .aer_ready   (aer_ready),
    .run_en      (run_en),
    .timer_en    (timer_en),
    .busy        (busy),
    .event_count (event_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; sample #1 after the edge. Neuron model: ack clears a request, keep_mask re-spikes.
  task automatic tick();
    @(posedge clk);
    #1;
    spike_req = (spike_req & ~ack_out) | keep_mask;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    spike_req = '0;
    keep_mask = '0;
    aer_ready = 1'b0;
    run_en    = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (aer_valid) break;
      tick();
    end
    check({tag, "_valid"}, 32'(aer_valid), 32'd1);
  endtask

  task automatic grant_expect(input string tag, input int exp_addr);
    wait_valid(tag);
    check({tag, "_addr"}, 32'(aer_addr), 32'(exp_addr));
    tick();
    check({tag, "_ack"}, 32'(ack_out), 32'd1 << exp_addr);
  endtask

  initial begin
    int pulses, low_pulses;
    int pt[3];
    logic stable;

    do_reset();
    check("rst_valid", 32'(aer_valid), 32'd0);
    check("rst_addr",  32'(aer_addr),  32'd0);
    check("rst_ack",   32'(ack_out),   32'd0);
    check("rst_timer", 32'(timer_en),  32'd0);
    check("rst_evt",   32'(event_count), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);

    // Single request, ready high: valid in cycle 1, ack in cycle 2 only.
    aer_ready = 1'b1;
    spike_req = 16'h0020;
    tick();
    check("single_valid", 32'(aer_valid), 32'd1);
    check("single_addr",  32'(aer_addr),  32'd5);
    check("single_ack0",  32'(ack_out),   32'd0);
    tick();
    check("single_ack",   32'(ack_out),   32'h0020);
    check("single_vlow",  32'(aer_valid), 32'd0);
    tick();
    check("single_ackclr", 32'(ack_out), 32'd0);
    tick();
    check("single_norevalid", 32'(aer_valid), 32'd0);
    check("single_idle_busy", 32'(busy), 32'd0);

    // Round-robin fairness with continuously re-spiking neurons 0, 8, 15.
    do_reset();
    aer_ready = 1'b1;
    keep_mask = 16'h8101;
    spike_req = 16'h8101;
    grant_expect("rr0", 0);
    grant_expect("rr1", 8);
    grant_expect("rr2", 15);
    grant_expect("rr3", 0);
    grant_expect("rr4", 8);
    grant_expect("rr5", 15);
    tick();
    check("rr_ack_single", 32'(ack_out), 32'd0);

    // Backpressure: hold valid/addr for 10 cycles, then one transfer.
    do_reset();
    spike_req = 16'h0008;
    tick();
    check("bp_valid", 32'(aer_valid), 32'd1);
    check("bp_addr",  32'(aer_addr),  32'd3);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!aer_valid || aer_addr != 4'd3 || ack_out != '0) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    aer_ready = 1'b1;
    tick();
    check("bp_ack",   32'(ack_out),   32'h0008);
    check("bp_vlow",  32'(aer_valid), 32'd0);
    tick();
    check("bp_ackclr", 32'(ack_out), 32'd0);

    // Wrap-around: last grant 15, then requests 1 and 15.
    do_reset();
    aer_ready = 1'b1;
    spike_req = 16'h8000;
    grant_expect("wrap_a", 15);
    tick();
    spike_req = 16'h8002;
    grant_expect("wrap_b", 1);
    grant_expect("wrap_c", 15);

    // Timer: run_en high 12 cycles, low 5.
    do_reset();
    pulses = 0;
    low_pulses = 0;
    pt = '{default: 0};
    run_en = 1'b1;
    for (int t = 1; t <= 17; t++) begin
      tick();
      if (timer_en) begin
        if (pulses < 3) pt[pulses] = t;
        pulses++;
        if (t > 12) low_pulses++;
      end
      if (t == 12) run_en = 1'b0;
    end
    check("tmr_count", 32'(pulses), 32'd3);
    check("tmr_p0", 32'(pt[0]), 32'd4);
    check("tmr_p1", 32'(pt[1]), 32'd8);
    check("tmr_p2", 32'(pt[2]), 32'd12);
    check("tmr_off", 32'(low_pulses), 32'd0);

    // Event counter over 5 accepted transfers.
    do_reset();
    aer_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      spike_req = spike_req | 16'h0001;
      grant_expect("evt", 0);
    end
    tick();
    check("evt_count", 32'(event_count), 32'(EXP_EVT));

    // Reset mid-GRANT: valid drops asynchronously, request is re-arbitrated from 0.
    aer_ready = 1'b0;
    spike_req = 16'h0004;
    wait_valid("rg");
    #2 resetn = 1'b0;
    #1;
    check("rg_valid", 32'(aer_valid), 32'd0);
    check("rg_ack",   32'(ack_out),   32'd0);
    check("rg_evt",   32'(event_count), 32'd0);
    check("rg_busy",  32'(busy),      32'd1);
    @(posedge clk);
    #1 resetn = 1'b1;
    tick();
    check("rg_revalid", 32'(aer_valid), 32'd1);
    check("rg_readdr",  32'(aer_addr),  32'd2);

    // Reset mid-ACK: ack pulse drops asynchronously.
    aer_ready = 1'b1;
    tick();
    check("ra_ack", 32'(ack_out), 32'h0004);
    #2 resetn = 1'b0;
    #1;
    check("ra_ackclr", 32'(ack_out), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/hidden_spike_arbiter.md
Name: hidden_spike_arbiter

Overview:
- Shares one address-event (AER) output bus among N_NEURON hidden neurons, using round-robin arbitration.
- Each neuron holds its spike_out request high until it receives an ack_in pulse. The arbiter grants one neuron, emits its index on the AER valid/ready bus, then pulses that neuron's ack.
- Also generates the shared timer_en tick that drives the neurons' refractory counters.
- Sits between the hidden-neuron array and the output layer or encoder.

Parameters:
- N_NEURON, 16, number of requesting hidden neurons (2..256).
- ADDR_W, 4, width of aer_addr; must satisfy 2**ADDR_W >= N_NEURON.
- STEP_CYCLES, 1000, clock cycles per timer_en tick (>= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- spike_req  input  N_NEURON  level requests, one bit per neuron spike_out.
- ack_out  output  N_NEURON  one-hot, one-cycle ack pulse to each neuron's ack_in.
- aer_valid  output  1  event present on aer_addr.
- aer_addr  output  ADDR_W  index of the granted neuron.
- aer_ready  input  1  downstream accepts the event.
- run_en  input  1  enables the timestep counter.
- timer_en  output  1  one-cycle tick every STEP_CYCLES enabled cycles.
- busy  output  1  high when the FSM is not in IDLE or any spike_req bit is set.
- event_count  output  16  accepted-event count (see Optional Feature).

Behaviour:
- Reset values (asynchronous assertion, synchronous deassertion assumed at the source):
  - FSM = IDLE; rr_ptr = 0.
  - ack_out = 0; aer_valid = 0; aer_addr = 0.
  - step counter = 0; timer_en = 0; event_count = 0.
- All outputs are registered.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If spike_req != 0, select winner = first set bit at index >= rr_ptr, wrapping modulo N_NEURON.
  - Register aer_addr = winner and aer_valid = 1; go to GRANT.
  - Latency: request sampled in cycle 0 gives aer_valid high in cycle 1.
- GRANT:
  - aer_valid and aer_addr are held stable until aer_ready = 1.
  - aer_ready may be high before valid; the transfer occurs on the first cycle both are high.
  - On transfer: aer_valid <= 0; ack_out[winner] <= 1; rr_ptr <= (winner + 1) mod N_NEURON; go to ACK.
  - Requests from other neurons arriving during GRANT are ignored until the next IDLE.
- ACK:
  - ack_out is high for exactly this one cycle, then all bits return to 0; go to IDLE.
  - The neuron clears its request on the edge ending ACK, so the winner's bit is already low in the next IDLE.
  - If the neuron re-spikes in that same cycle (spike has priority over ack in the neuron), its bit stays high. That is treated as a new event and is arbitrated normally.
- Throughput: minimum 3 cycles per event (IDLE, GRANT, ACK) with aer_ready held high.
- Fairness: a continuously requesting neuron waits at most N_NEURON-1 grants.
- Index range: bits at index >= N_NEURON do not exist. rr_ptr wraps from N_NEURON-1 to 0.
- Timestep counter:
  - Counts 0..STEP_CYCLES-1 only while run_en = 1, and holds its value while run_en = 0.
  - timer_en = 1 for one cycle when the counter wraps to 0 (its terminal count is reached).
  - timer_en is independent of the FSM; it is never suppressed by pending events.
- busy = (FSM != IDLE) | (|spike_req), computed combinationally from registered state.
- Reset during GRANT or ACK:
  - The pending event is dropped and aer_valid and ack_out clear immediately.
  - The neuron's request stays pending and is re-arbitrated after reset, starting from index 0.

Optional Feature:
- Macro: HIDDEN_ARB_EVENT_CNT_EN.
- Defined:
  - event_count increments by 1 on each accepted AER transfer (aer_valid & aer_ready).
  - It saturates at 16'hFFFF and clears to 0 on reset.
- Undefined: event_count is tied to 16'h0000 and the counter logic is not synthesised.

Decomposition:
- Package hidden_arb_pkg holds:
  - arb_state_t enum (IDLE=2'd0, GRANT=2'd1, ACK=2'd2);
  - default widths HA_ADDR_W = 4 and HA_CNT_W = 16.
- One sub-module, rr_priority_pick:
  - purely combinational, parameterised by N_NEURON;
  - inputs: req vector and rr_ptr; outputs: found flag and winner index;
  - implemented as rotate, then lowest-set-bit search, then un-rotate.
- The top level holds the FSM, the step counter and the event counter.

Test Plan:
- Single request, ready held high: spike_req = 16'h0020 from cycle 0.
  - Expect aer_valid = 1 and aer_addr = 5 in cycle 1, and ack_out = 16'h0020 in cycle 2 only.
  - Model the neuron clearing its request after ack; aer_valid must not reassert.
- Round-robin fairness: spike_req = 16'h8101 held, neuron model re-asserts its request after each ack.
  - Expect grant order 0, 8, 15, 0, 8, 15, with exactly one ack per grant.
- Backpressure: aer_ready = 0 for 10 cycles after aer_valid rises with aer_addr = 3.
  - aer_valid and aer_addr must stay stable for those cycles, with no ack_out.
  - Raising aer_ready produces one transfer and ack_out[3] in the following cycle.
- Wrap-around: last grant = 15, then spike_req = 16'h8002.
  - Expect next grant = 1, then 15.
- Timer: STEP_CYCLES = 4, run_en high for 12 cycles then low for 5.
  - Expect exactly 3 timer_en pulses, 4 cycles apart, and none while run_en = 0.
- Reset and counter: assert resetn = 0 mid-GRANT.
  - aer_valid and ack_out must go low asynchronously; event_count = 0.
  - With HIDDEN_ARB_EVENT_CNT_EN defined, 5 accepted transfers give event_count = 5; undefined gives 0.
